drc_pxl_packer: RTL

//   Downstream neighbour of the resizer stage. Packs a stream of resized pixels
//   (RGB565 or 8-bit grayscale) into fixed-width bus words for the frame-buffer

---
 rtl/drc_pxl_packer_pkg.sv | 12 +
 rtl/drc_pxl_packer.sv | 99 +++++++++
 2 files changed

// File: rtl/drc_pxl_packer_pkg.sv
// Shared constants for the pixel packer: supported pixel widths and a
// helper used by the elaboration-time parameter check.
package drc_pxl_packer_pkg;

  localparam int unsigned RGB_PXL_W = 16;
  localparam int unsigned GS_PXL_W  = 8;

  function automatic bit pxl_w_ok(input int unsigned w);
    return (w == RGB_PXL_W) || (w == GS_PXL_W);
  endfunction

endpackage

// File: rtl/drc_pxl_packer.sv
// Packs RGB565 / 8-bit grayscale pixels little-endian into DAT_W-bit words
// with a byte-keep mask and frame-last marker; registered output.
module drc_pxl_packer
  import drc_pxl_packer_pkg::*;
#(
  parameter int unsigned PXL_W = RGB_PXL_W,
  parameter int unsigned DAT_W = 32,
  localparam int unsigned NPW = DAT_W / PXL_W,
  localparam int unsigned KEEP_W = DAT_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PXL_W-1:0]  bwd_pxl_dat_i,
  input  logic              bwd_pxl_last_i,
  input  logic              bwd_pxl_vld_i,
  output logic              bwd_pxl_rdy_o,
  output logic [DAT_W-1:0]  fwd_dat_o,
  output logic [KEEP_W-1:0] fwd_keep_o,
  output logic              fwd_last_o,
  output logic              fwd_vld_o,
  input  logic              fwd_rdy_i
);

  localparam int unsigned PB = PXL_W / 8;
  localparam int unsigned CNT_W = (NPW > 1) ? $clog2(NPW) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NPW - 1);

  if (!pxl_w_ok(PXL_W) || (DAT_W < PXL_W) || ((DAT_W % PXL_W) != 0)) begin : g_param_err
    $error("drc_pxl_packer: PXL_W must be 8 or 16 and divide DAT_W");
  end

  logic [DAT_W-1:0]  acc_q, acc_mrg;
  logic [KEEP_W-1:0] keep_q, keep_mrg;
  logic [CNT_W-1:0]  cnt_q;

  logic [DAT_W-1:0]  dat_q;
  logic [KEEP_W-1:0] okeep_q;
  logic              last_q;
  logic              vld_q;

  logic accept;
  logic complete;

  assign bwd_pxl_rdy_o = ~vld_q | fwd_rdy_i;
  assign accept        = bwd_pxl_vld_i & bwd_pxl_rdy_o;
  assign complete      = accept & (bwd_pxl_last_i | (cnt_q == CNT_MAX));

  // Accumulator with the incoming pixel dropped into its lane; lanes not yet
  // filled stay zero because the accumulator is cleared at every word boundary.
  always_comb begin
    acc_mrg  = acc_q;
    keep_mrg = keep_q;
    for (int unsigned k = 0; k < NPW; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        acc_mrg[k*PXL_W +: PXL_W] = bwd_pxl_dat_i;
        keep_mrg[k*PB +: PB]      = '1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      keep_q <= '0;
      cnt_q  <= '0;
    end else if (complete) begin
      acc_q  <= '0;
      keep_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      acc_q  <= acc_mrg;
      keep_q <= keep_mrg;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // A completing word overrides the handshake clear so words go out back-to-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q   <= '0;
      okeep_q <= '0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else if (complete) begin
      dat_q   <= acc_mrg;
      okeep_q <= keep_mrg;
      last_q  <= bwd_pxl_last_i;
      vld_q   <= 1'b1;
    end else if (fwd_rdy_i) begin
      vld_q   <= 1'b0;
    end
  end

  assign fwd_dat_o  = dat_q;
  assign fwd_keep_o = okeep_q;
  assign fwd_last_o = last_q;
  assign fwd_vld_o  = vld_q;

endmodule
